// File: rtl/rv32i_fetch.sv
// rv32i_fetch: RV32I fetch stage with credit-limited imem requests, instruction FIFO and redirect flush
module rv32i_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] occ_q, occ_d, out_q, out_d, drop_q, drop_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [31:0]   data_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem   [FIFO_DEPTH];
    logic          req_fire, rsp_fire, keep, deq;
    logic [31:0]   target;
    logic          unused_ok;

    assign unused_ok      = ^redirect_pc[1:0];
    assign target         = {redirect_pc[31:2], 2'b00};
    assign imem_req_valid = rst_n && (({1'b0, occ_q} + {1'b0, out_q}) < DEPTH);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && (out_q != '0);
    assign keep           = rsp_fire && (drop_q == '0) && !redirect_valid;
    assign instr_valid    = occ_q != '0;
    assign deq            = instr_valid && instr_ready && !redirect_valid;
    assign instr          = instr_valid ? data_mem[rd_q] : 32'h0;
    assign instr_pc       = instr_valid ? pc_mem[rd_q] : 32'h0;

    // Next state: redirect clears the FIFO and turns every in-flight request into a drop
    always_comb begin
        out_d      = out_q + CW'(req_fire) - CW'(rsp_fire);
        fetch_pc_d = redirect_valid ? target : req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        rsp_pc_d   = redirect_valid ? target : keep ? rsp_pc_q + 32'd4 : rsp_pc_q;
        occ_d      = redirect_valid ? '0 : occ_q + CW'(keep) - CW'(deq);
        drop_d     = redirect_valid ? out_d : drop_q - CW'(rsp_fire && (drop_q != '0));
        wr_d       = redirect_valid ? '0 : wr_q + AW'(keep);
        rd_d       = redirect_valid ? '0 : rd_q + AW'(deq);
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            occ_q      <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            occ_q      <= occ_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    // FIFO storage: kept responses written with the PC they belong to
    always_ff @(posedge clk) begin
        if (keep) begin
            data_mem[wr_q] <= imem_rsp_data;
            pc_mem[wr_q]   <= rsp_pc_q;
        end
    end
endmodule
